// File: rtl/ws2812_rx_if.sv
// Decoded-pixel output bundle of the WS2812 line receiver.
// The decoder drives the master side; the consumer listens on the slave side.
interface ws2812_rx_if;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_idx;
    logic        frame_done;
    logic        frame_err;

    modport master (
        output pixel_data, pixel_valid, pixel_idx, frame_done, frame_err
    );

    modport slave (
        input  pixel_data, pixel_valid, pixel_idx, frame_done, frame_err
    );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 single-wire decoder: classifies high-pulse widths into bits, builds GRB words, flags frames.
// Optional macro WS2812_RX_FWD_EN turns dout into a chained-LED style forwarded data line.
module ws2812_rx #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BIT_THRESH = 6,
    parameter int MIN_HIGH   = 2,
    parameter int MAX_HIGH   = 12,
    parameter int RES        = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic        dout,
    ws2812_rx_if.master px
);

    localparam int CW = (RES > 2) ? $clog2(RES) : 1;
    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam logic [CW-1:0] RES_LAST   = CW'(RES - 1);
    localparam logic [HW-1:0] HIGH_MAX   = HW'(MAX_HIGH);
    localparam logic [HW-1:0] HIGH_MIN   = HW'(MIN_HIGH);
    localparam logic [HW-1:0] HIGH_THR   = HW'(BIT_THRESH);

    if (CLK_FREQ <= 0 || MIN_HIGH < 1 || BIT_THRESH <= MIN_HIGH ||
        MAX_HIGH < BIT_THRESH || RES < 2) begin : g_bad_cfg
        $error("ws2812_rx: inconsistent timing parameters");
    end

    typedef enum logic [1:0] {
        WAIT_RES,
        IDLE,
        HIGH,
        LOW
    } state_t;

    logic [1:0]    sync_reg;
    logic          din_s;

    state_t        state_reg,       state_next;
    logic [CW-1:0] low_cnt_reg,     low_cnt_next;
    logic [HW-1:0] high_cnt_reg,    high_cnt_next;
    logic [4:0]    bit_cnt_reg,     bit_cnt_next;
    logic [23:0]   shift_reg,       shift_next;
    logic [23:0]   pixel_data_reg,  pixel_data_next;
    logic          pixel_valid_reg, pixel_valid_next;
    logic [7:0]    pixel_idx_reg,   pixel_idx_next;
    logic          frame_done_reg,  frame_done_next;
    logic          frame_err_reg,   frame_err_next;
    logic          bit_val;

    assign din_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg        <= '0;
            state_reg       <= WAIT_RES;
            low_cnt_reg     <= '0;
            high_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            pixel_data_reg  <= '0;
            pixel_valid_reg <= 1'b0;
            pixel_idx_reg   <= '0;
            frame_done_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            sync_reg        <= {sync_reg[0], din};
            state_reg       <= state_next;
            low_cnt_reg     <= low_cnt_next;
            high_cnt_reg    <= high_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            pixel_data_reg  <= pixel_data_next;
            pixel_valid_reg <= pixel_valid_next;
            pixel_idx_reg   <= pixel_idx_next;
            frame_done_reg  <= frame_done_next;
            frame_err_reg   <= frame_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        low_cnt_next     = low_cnt_reg;
        high_cnt_next    = high_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        pixel_data_next  = pixel_data_reg;
        pixel_valid_next = 1'b0;
        frame_done_next  = 1'b0;
        frame_err_next   = 1'b0;
        bit_val          = (high_cnt_reg >= HIGH_THR);
        // The index advances the cycle after a word strobe so the strobe carries its own index.
        pixel_idx_next   = (pixel_valid_reg && pixel_idx_reg != 8'hFF) ? pixel_idx_reg + 8'd1
                                                                        : pixel_idx_reg;

        unique case (state_reg)
            WAIT_RES: begin
                if (din_s) begin
                    low_cnt_next = '0;
                end else if (low_cnt_reg == RES_LAST) begin
                    low_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    low_cnt_next = low_cnt_reg + 1'b1;
                end
            end

            IDLE: begin
                if (din_s) begin
                    high_cnt_next = HW'(1);
                    state_next    = HIGH;
                end
            end

            HIGH: begin
                if (din_s) begin
                    // Overlong pulse is flagged as soon as it passes the limit, not at its end.
                    if (high_cnt_reg == HIGH_MAX) begin
                        frame_err_next = 1'b1;
                        bit_cnt_next   = '0;
                        pixel_idx_next = '0;
                        low_cnt_next   = '0;
                        state_next     = WAIT_RES;
                    end else begin
                        high_cnt_next = high_cnt_reg + 1'b1;
                    end
                end else if (high_cnt_reg < HIGH_MIN) begin
                    frame_err_next = 1'b1;
                    bit_cnt_next   = '0;
                    pixel_idx_next = '0;
                    low_cnt_next   = '0;
                    state_next     = WAIT_RES;
                end else begin
                    shift_next   = {shift_reg[22:0], bit_val};
                    low_cnt_next = CW'(1);
                    state_next   = LOW;
                    if (bit_cnt_reg == 5'd23) begin
                        pixel_data_next  = {shift_reg[22:0], bit_val};
                        pixel_valid_next = 1'b1;
                        bit_cnt_next     = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
            end

            LOW: begin
                if (din_s) begin
                    high_cnt_next = HW'(1);
                    state_next    = HIGH;
                end else if (low_cnt_reg == RES_LAST) begin
                    // Latch gap: a partial word makes the whole frame malformed.
                    frame_done_next = (bit_cnt_reg == 5'd0);
                    frame_err_next  = (bit_cnt_reg != 5'd0);
                    bit_cnt_next    = '0;
                    pixel_idx_next  = '0;
                    low_cnt_next    = '0;
                    state_next      = IDLE;
                end else begin
                    low_cnt_next = low_cnt_reg + 1'b1;
                end
            end

            default: state_next = WAIT_RES;
        endcase
    end

    assign px.pixel_data  = pixel_data_reg;
    assign px.pixel_valid = pixel_valid_reg;
    assign px.pixel_idx   = pixel_idx_reg;
    assign px.frame_done  = frame_done_reg;
    assign px.frame_err   = frame_err_reg;

`ifdef WS2812_RX_FWD_EN
    logic fwd_active_reg;
    logic dout_reg;

    // Word 0 is consumed locally; everything after it is passed down the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_active_reg <= 1'b0;
            dout_reg       <= 1'b0;
        end else begin
            if (frame_done_reg || frame_err_reg) begin
                fwd_active_reg <= 1'b0;
            end else if (pixel_valid_reg) begin
                fwd_active_reg <= 1'b1;
            end
            dout_reg <= din_s & fwd_active_reg;
        end
    end

    assign dout = dout_reg;
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: drives WS2812 line timing, checks words, frame strobes, latency, dout.
module tb_ws2812_rx;

    localparam int RES = 500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;
    logic dout;

    ws2812_rx_if px ();

    ws2812_rx #(
        .CLK_FREQ   (10_000_000),
        .BIT_THRESH (6),
        .MIN_HIGH   (2),
        .MAX_HIGH   (12),
        .RES        (RES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .dout  (dout),
        .px    (px)
    );

    always #5 clk = ~clk;

    // kind: 0 pixel, 1 frame_done, 2 frame_err; ref_sel: 1 last rise, 2 last fall
    typedef struct {
        int          kind;
        logic [23:0] data;
        int          idx;
        int          ref_sel;
        int          offs;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   last_rise    = 0;
    int   last_fall    = 0;
    int   fwd_tag      = 0;
    logic fwd_win      = 1'b0;
    logic [2:0] din_hist = '0;
    int   tag_hist [3] = '{0, 0, 0};
    exp_t mon_e;
    int   mon_k;
    logic exp_dout;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        din_hist    <= {din_hist[1:0], din};
        tag_hist[0] <= fwd_tag;
        tag_hist[1] <= tag_hist[0];
        tag_hist[2] <= tag_hist[1];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic pulse(input int h, input int l);
        @(negedge clk);
        din = 1'b1;
        last_rise = cyc;
        repeat (h - 1) @(negedge clk);
        @(negedge clk);
        din = 1'b0;
        last_fall = cyc;
        repeat (l - 1) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(7, 6);
        else   pulse(4, 8);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            din = 1'b0;
        end
    endtask

    task automatic push(input int kind, input logic [23:0] data, input int idx,
                        input int ref_sel, input int offs);
        exp_t e;
        e.kind = kind; e.data = data; e.idx = idx; e.ref_sel = ref_sel; e.offs = offs;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [23:0] w, input int idx);
        push(0, w, idx, 2, 3);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic end_frame(input int kind);
        push(kind, 24'h0, 0, 2, RES + 2);
        gap(RES + 20);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data"},  32'(px.pixel_data),  32'd0);
        check_eq({tag, "_valid"}, 32'(px.pixel_valid), 32'd0);
        check_eq({tag, "_idx"},   32'(px.pixel_idx),   32'd0);
        check_eq({tag, "_done"},  32'(px.frame_done),  32'd0);
        check_eq({tag, "_err"},   32'(px.frame_err),   32'd0);
        check_eq({tag, "_dout"},  32'(dout),           32'd0);
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (px.pixel_valid || px.frame_done || px.frame_err)) begin
            check_eq("done_err_excl", 32'(px.frame_done & px.frame_err), 32'd0);
            if (sb.size() == 0) begin
                check_eq("spurious_strobe", 32'({px.pixel_valid, px.frame_done, px.frame_err}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                mon_k = px.pixel_valid ? 0 : (px.frame_done ? 1 : 2);
                check_eq("strobe_kind", 32'(mon_k), 32'(mon_e.kind));
                if (mon_k == 0) begin
                    $display("[TB] pixel idx=%0d data=%06h cyc=%0d", px.pixel_idx, px.pixel_data, cyc);
                    check_eq("pixel_data", 32'(px.pixel_data), 32'(mon_e.data));
                    check_eq("pixel_idx",  32'(px.pixel_idx),  32'(mon_e.idx));
                end else begin
                    $display("[TB] %s cyc=%0d", (mon_k == 1) ? "frame_done" : "frame_err", cyc);
                end
                if (mon_e.ref_sel != 0)
                    check_eq("strobe_latency", 32'(cyc),
                             32'(((mon_e.ref_sel == 1) ? last_rise : last_fall) + mon_e.offs));
            end
        end
    end

    // dout must be din delayed three clocks once word 0 of the frame has been consumed.
    always @(negedge clk) begin
        if (fwd_win) begin
`ifdef WS2812_RX_FWD_EN
            exp_dout = din_hist[2] & (tag_hist[2] >= 1);
`else
            exp_dout = 1'b0;
`endif
            check_eq("dout", 32'(dout), 32'(exp_dout));
        end
    end

    initial begin
        logic [23:0] w;
        int          h;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        gap(RES + 10);

        // Single word frame
        send_word(24'hFF0000, 0);
        end_frame(1);

        // Two-word frame, index increments
        send_word(24'h800080, 0);
        send_word(24'h00FF00, 1);
        end_frame(1);

        // Truncated frame: 10 bits then latch gap
        w = 24'hB5A000;
        for (int i = 23; i >= 14; i--) send_bit(w[i]);
        end_frame(2);
        send_word(24'h123456, 0);
        end_frame(1);

        // Overlong high after 5 bits: error 13 synced cycles after the synced rise
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        push(2, 24'h0, 0, 1, 15);
        pulse(20, 8);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        gap(RES + 20);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        send_word(24'h0000FF, 0);
        end_frame(1);

        // Width boundaries: 2 and 12 accepted, 5 -> '0', 6 -> '1', then a width-1 glitch errors
        w = 24'hC3A53D;
        push(0, w, 0, 2, 3);
        for (int i = 23; i >= 0; i--) begin
            if (i == 1)       h = 5;
            else if (i == 0)  h = 6;
            else if (w[i])    h = (i % 3 == 0) ? 12 : 7;
            else              h = (i % 3 == 0) ? 2 : 4;
            pulse(h, 8);
        end
        push(2, 24'h0, 0, 2, 3);
        pulse(1, 8);
        gap(RES + 20);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-frame: outputs clear, remaining bits ignored until a full gap
        w = 24'hAAAAAA;
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        for (int i = 11; i >= 0; i--) send_bit(w[i]);
        gap(RES + 20);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        send_word(24'h5A5A5A, 0);
        end_frame(1);

        // Three-word frame with dout monitoring
        fwd_win = 1'b1;
        fwd_tag = 0;
        send_word(24'h123456, 0);
        fwd_tag = 1;
        send_word(24'hABCDEF, 1);
        fwd_tag = 2;
        send_word(24'h0F0F0F, 2);
        end_frame(1);
        fwd_win = 1'b0;
        fwd_tag = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
